ps2_mouse_rx: RTL

PS2_MOUSE_RX -- requirements
Module: ps2_mouse_rx

---
 rtl/ps2_mouse_rx_if.sv | 27 ++
 rtl/ps2_mouse_rx.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_rx_if.sv
// PS/2 mouse receiver bus: raw PS/2 lines in, decoded packet fields and status strobes out.
// The mouse/consumer side uses master; the receiver uses slave.
interface ps2_mouse_rx_if;
  logic       PS2_CLK;
  logic       PS2_DATA;
  logic       left;
  logic       right;
  logic       middle;
  logic [8:0] dx;
  logic [8:0] dy;
  logic [3:0] wheel;
  logic       packet_valid;
  logic       transfer_ready;
  logic       frame_error;

  modport master (
    output PS2_CLK, PS2_DATA,
    input  left, right, middle, dx, dy, wheel,
    input  packet_valid, transfer_ready, frame_error
  );

  modport slave (
    input  PS2_CLK, PS2_DATA,
    output left, right, middle, dx, dy, wheel,
    output packet_valid, transfer_ready, frame_error
  );
endinterface

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse packet receiver: synchronizes the raw PS/2 lines, deframes 11-bit frames
// and assembles 3- or 4-byte packets into button, motion and wheel fields.
module ps2_mouse_rx #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int PACKET_BYTES   = 4
) (
  input logic          clk,
  input logic          reset,
  ps2_mouse_rx_if.slave bus
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t          r_state, w_state_nxt;
  logic [1:0]      r_clk_sync, r_dat_sync;
  logic            r_clk_prev;
  logic [2:0]      r_bit_cnt, w_bit_nxt;
  logic [7:0]      r_shift, w_shift_nxt;
  logic            r_perr, w_perr_nxt;
  logic [1:0]      r_byte_cnt;
  logic [TO_W-1:0] r_to_cnt;
  logic [4:0]      r_hdr;
  logic [7:0]      r_b1, r_b2;

  logic            r_left, r_right, r_middle;
  logic [8:0]      r_dx, r_dy;
  logic [3:0]      r_wheel;
  logic            r_packet_valid, r_xfer_ready, r_frame_error;

  logic            w_fall, w_dat, w_to_hit, w_timeout;
  logic            w_start, w_byte_ok, w_bit_err, w_sync_err, w_last, w_err;

  // Synchronizers idle high so a released bus never looks like a falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[0], bus.PS2_CLK};
      r_dat_sync <= {r_dat_sync[0], bus.PS2_DATA};
      r_clk_prev <= r_clk_sync[1];
    end
  end

  assign w_fall = r_clk_prev & ~r_clk_sync[1];
  assign w_dat  = r_dat_sync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_to_cnt <= '0;
    else if (w_fall)   r_to_cnt <= '0;
    else if (!w_to_hit) r_to_cnt <= r_to_cnt + TO_W'(1);
  end

  assign w_to_hit  = (r_to_cnt == TO_W'(TIMEOUT_CYCLES));
  assign w_timeout = w_to_hit && ((r_state != IDLE) || (r_byte_cnt != 2'd0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_perr    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_perr    <= w_perr_nxt;
    end
  end

  // Timeout has priority: an edge landing in the expiry cycle is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_perr_nxt  = r_perr;
    w_start     = 1'b0;
    w_byte_ok   = 1'b0;
    w_bit_err   = 1'b0;
    if (w_timeout) begin
      w_state_nxt = IDLE;
    end else if (w_fall) begin
      case (r_state)
        IDLE: begin
          if (!w_dat) begin
            w_state_nxt = DATA;
            w_bit_nxt   = '0;
            w_start     = 1'b1;
          end
        end
        DATA: begin
          w_shift_nxt = {w_dat, r_shift[7:1]};
          w_bit_nxt   = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) w_state_nxt = PARITY;
        end
        PARITY: begin
          w_perr_nxt  = ~(^{w_dat, r_shift});
          w_state_nxt = STOP;
        end
        STOP: begin
          if (w_dat && !r_perr) w_byte_ok = 1'b1;
          else                  w_bit_err = 1'b1;
          w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Byte0 must carry the always-one bit 3, otherwise we are out of packet alignment.
  assign w_sync_err = w_byte_ok && (r_byte_cnt == 2'd0) && !r_shift[3];
  assign w_last     = w_byte_ok && !w_sync_err && (r_byte_cnt == 2'(PACKET_BYTES - 1));
  assign w_err      = w_timeout | w_bit_err | w_sync_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_byte_cnt     <= '0;
      r_hdr          <= '0;
      r_b1           <= '0;
      r_b2           <= '0;
      r_left         <= 1'b0;
      r_right        <= 1'b0;
      r_middle       <= 1'b0;
      r_dx           <= '0;
      r_dy           <= '0;
      r_wheel        <= '0;
      r_packet_valid <= 1'b0;
      r_xfer_ready   <= 1'b0;
      r_frame_error  <= 1'b0;
    end else begin
      r_packet_valid <= 1'b0;
      r_frame_error  <= w_err;
      if (w_err) begin
        r_byte_cnt <= '0;
      end else if (w_last) begin
        r_byte_cnt     <= '0;
        r_left         <= r_hdr[0];
        r_right        <= r_hdr[1];
        r_middle       <= r_hdr[2];
        r_dx           <= {r_hdr[3], r_b1};
        r_packet_valid <= 1'b1;
        r_xfer_ready   <= 1'b1;
        if (PACKET_BYTES == 4) begin
          r_dy    <= {r_hdr[4], r_b2};
          r_wheel <= r_shift[3:0];
        end else begin
          r_dy    <= {r_hdr[4], r_shift};
          r_wheel <= '0;
        end
      end else if (w_byte_ok) begin
        case (r_byte_cnt)
          2'd0:    r_hdr <= {r_shift[5:4], r_shift[2:0]};
          2'd1:    r_b1  <= r_shift;
          default: r_b2  <= r_shift;
        endcase
        r_byte_cnt <= r_byte_cnt + 2'd1;
      end
      if (w_start && (r_byte_cnt == 2'd0)) r_xfer_ready <= 1'b0;
    end
  end

  assign bus.left           = r_left;
  assign bus.right          = r_right;
  assign bus.middle         = r_middle;
  assign bus.dx             = r_dx;
  assign bus.dy             = r_dy;
  assign bus.wheel          = r_wheel;
  assign bus.packet_valid   = r_packet_valid;
  assign bus.transfer_ready = r_xfer_ready;
  assign bus.frame_error    = r_frame_error;

endmodule
